// File: rtl/locked_adder_key_loader.sv
// ============================================================================
// locked_adder_key_loader
// Serial, even-parity key loader and operand gate for the XOR-locked adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module locked_adder_key_loader #(
  parameter int KEY_W = 32,
  parameter int OP_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_start_i,
  input  logic             key_sdata_i,
  input  logic             key_svalid_i,
  input  logic [OP_W-1:0]  add1_i,
  input  logic [OP_W-1:0]  add2_i,
  output logic [KEY_W-1:0] keyinput_o,
  output logic [OP_W-1:0]  add1_o,
  output logic [OP_W-1:0]  add2_o,
  output logic             key_valid_o,
  output logic             key_err_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(KEY_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_PARITY = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [KEY_W-1:0]   r_sreg;
  logic               r_par;
  logic [KEY_W-1:0]   r_key;
  logic               r_valid;
  logic               r_err;
  logic [OP_W-1:0]    r_add1;
  logic [OP_W-1:0]    r_add2;
  logic               w_bit_take;
  logic               w_last_bit;

  // load_start_i outranks a simultaneous data bit, so such a bit is dropped.
  assign w_bit_take = (r_state == ST_SHIFT) && key_svalid_i && !load_start_i;
  assign w_last_bit = (r_cnt == CNT_W'(KEY_W - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load_start_i) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (load_start_i)                    w_state_nxt = ST_SHIFT;
        else if (key_svalid_i && w_last_bit) w_state_nxt = ST_PARITY;
      end
      ST_PARITY: begin
        if (load_start_i)      w_state_nxt = ST_SHIFT;
        else if (key_svalid_i) w_state_nxt = (r_par ^ key_sdata_i) ? ST_ERROR : ST_COMMIT;
      end
      ST_COMMIT, ST_ERROR: begin
        w_state_nxt = load_start_i ? ST_SHIFT : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_par   <= 1'b0;
      r_key   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_add1  <= '0;
      r_add2  <= '0;
    end else begin
      // Gate uses the key_valid state held before this edge.
      r_add1 <= r_valid ? add1_i : '0;
      r_add2 <= r_valid ? add2_i : '0;

      if (r_state == ST_COMMIT) begin
        r_key   <= r_sreg;
        r_valid <= 1'b1;
      end
      if (r_state == ST_ERROR) r_err <= 1'b1;

      // A restart still lets a pending commit land its key, but the new
      // frame leaves the status flags cleared.
      if (load_start_i) begin
        r_cnt   <= '0;
        r_sreg  <= '0;
        r_par   <= 1'b0;
        r_valid <= 1'b0;
        r_err   <= 1'b0;
      end else if (w_bit_take) begin
        r_sreg <= {r_sreg[KEY_W-2:0], key_sdata_i};
        r_cnt  <= r_cnt + 1'b1;
        r_par  <= r_par ^ key_sdata_i;
      end
    end
  end

  assign keyinput_o  = r_key;
  assign add1_o      = r_add1;
  assign add2_o      = r_add2;
  assign key_valid_o = r_valid;
  assign key_err_o   = r_err;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
